// File: rtl/counter32_sequencer_pkg.sv
// Shared constants for the counter32 sequencer: counter mode codes and FSM states.
package counter32_pkg;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_UP3  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/counter32_sequencer_if.sv
// Command, counter-drive and status signals between system control and the sequencer.
interface counter32_sequencer_if #(
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned WRAP_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [3:0]        cmd_data;
    logic [LEN_W-1:0]  cmd_len;
    logic              abort;
    logic              cnt_enable;
    logic [1:0]        cnt_mode;
    logic [3:0]        cnt_d;
    logic              cnt_load;
    logic              cnt_rco;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              load_seen;

    // Master is the control side, which also stands in for the counter's load/rco.
    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_len, abort, cnt_load, cnt_rco,
        input  cmd_ready, cnt_enable, cnt_mode, cnt_d, busy, done, aborted, wrap_cnt,
               load_seen
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_len, abort, cnt_load, cnt_rco,
        output cmd_ready, cnt_enable, cnt_mode, cnt_d, busy, done, aborted, wrap_cnt,
               load_seen
    );
endinterface

// File: rtl/counter32_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;
endmodule

// File: rtl/counter32_sequencer.sv
// Runs one command at a time against the 32-bit counter: exact-length enable window,
// rco/load bookkeeping, and a done/aborted report.
module counter32_sequencer
    import counter32_pkg::*;
#(
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned WRAP_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    counter32_sequencer_if.slave  bus
);
    state_e             r_state;
    state_e             w_state_next;
    logic [LEN_W-1:0]   r_remaining;
    logic [LEN_W-1:0]   w_eff_len;
    logic               w_accept;
    logic               w_last;
    logic               r_cnt_enable;
    logic [1:0]         r_cnt_mode;
    logic [3:0]         r_cnt_d;
    logic               r_busy;
    logic               r_done;
    logic               r_aborted;
    logic               r_load_seen;
    logic [WRAP_W-1:0]  w_wrap_cnt;

    always_comb begin
        w_accept     = (r_state == S_IDLE) && bus.cmd_valid;
        // A load is a single-cycle operation regardless of the requested length.
        w_eff_len    = (bus.cmd_op == MODE_LOAD) ? LEN_W'(1) : bus.cmd_len;
        w_last       = (r_remaining == LEN_W'(1));
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_eff_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort || w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_remaining  <= '0;
            r_cnt_enable <= 1'b0;
            r_cnt_mode   <= MODE_UP;
            r_cnt_d      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_load_seen  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt_enable <= (w_state_next == S_RUN);
            r_busy       <= (w_state_next != S_IDLE);
            r_done       <= (w_state_next == S_DONE);
            if (w_accept) begin
                r_cnt_mode  <= bus.cmd_op;
                r_cnt_d     <= bus.cmd_data;
                r_remaining <= w_eff_len;
                r_aborted   <= 1'b0;
                r_load_seen <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_remaining <= r_remaining - LEN_W'(1);
                if (bus.abort) begin
                    r_aborted <= 1'b1;
                end
            end
            if (r_cnt_enable && bus.cnt_load) begin
                r_load_seen <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W (WRAP_W)
    ) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_accept),
        .inc   (r_cnt_enable && bus.cnt_rco),
        .q     (w_wrap_cnt)
    );

    assign bus.cmd_ready  = (r_state == S_IDLE);
    assign bus.cnt_enable = r_cnt_enable;
    assign bus.cnt_mode   = r_cnt_mode;
    assign bus.cnt_d      = r_cnt_d;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.aborted    = r_aborted;
    assign bus.wrap_cnt   = w_wrap_cnt;
    assign bus.load_seen  = r_load_seen;
endmodule

// File: tb/tb_counter32_sequencer.sv
// Directed bench for counter32_sequencer; the counter's load output is modelled from mode.
module tb_counter32_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   en_cnt;
    int   first_en;
    int   done_idx;
    int   done_cnt;
    logic ab_at_done;
    logic [1:0] mode_seen;
    logic [3:0] d_seen;

    counter32_sequencer_if #(.LEN_W(16), .WRAP_W(8)) bus ();

    counter32_sequencer #(
        .LEN_W  (16),
        .WRAP_W (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.cnt_load = bus.cnt_enable && (bus.cnt_mode == 2'b11);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] data, input logic [15:0] len);
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Sample index j=0 is just after the accepting edge.
    task automatic observe(input int n);
        en_cnt = 0; first_en = -1; done_idx = -1; done_cnt = 0; ab_at_done = 1'bx;
        mode_seen = 2'bxx; d_seen = 4'hx;
        for (int j = 0; j < n; j++) begin
            if (bus.cnt_enable) begin
                if (first_en < 0) begin
                    first_en = j; mode_seen = bus.cnt_mode; d_seen = bus.cnt_d;
                end
                en_cnt++;
            end
            if (bus.done) begin
                if (done_idx < 0) begin
                    done_idx = j; ab_at_done = bus.aborted;
                end
                done_cnt++;
            end
            if (j < n - 1) tick();
        end
    endtask

    task automatic test_reset();
        n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", bus.cmd_ready); end
        n_checks++; if (bus.cnt_enable !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL rst_ctrl got en=%b busy=%b done=%b exp=0/0/0", bus.cnt_enable, bus.busy, bus.done); end
        n_checks++; if (bus.cnt_mode !== 2'b00 || bus.cnt_d !== 4'h0) begin
            n_fail++; $display("FAIL rst_drive got mode=%b d=%h exp=00/0", bus.cnt_mode, bus.cnt_d); end
        n_checks++; if (bus.aborted !== 1'b0 || bus.wrap_cnt !== 8'h00 || bus.load_seen !== 1'b0) begin
            n_fail++; $display("FAIL rst_status got ab=%b wrap=%h ls=%b exp=0/00/0", bus.aborted, bus.wrap_cnt, bus.load_seen); end
    endtask

    task automatic test_reset_mid_run();
        logic seen_done;
        issue(2'b00, 4'h0, 16'd50);
        tick(); tick();
        n_checks++; if (bus.cnt_enable !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_en got=%b exp=1", bus.cnt_enable); end
        reset = 1'b1;
        #1;
        n_checks++; if (bus.cnt_enable !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_async got en=%b busy=%b ready=%b exp=0/0/1", bus.cnt_enable, bus.busy, bus.cmd_ready); end
        seen_done = 1'b0;
        tick(); seen_done |= bus.done;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); seen_done |= bus.done; end
        n_checks++; if (seen_done !== 1'b0 || bus.cnt_enable !== 1'b0) begin
            n_fail++; $display("FAIL midrst_nodone got done=%b en=%b exp=0/0", seen_done, bus.cnt_enable); end
    endtask

    task automatic test_mode_up();
        issue(2'b00, 4'h0, 16'd5);
        observe(10);
        n_checks++; if (en_cnt !== 5 || first_en !== 0) begin
            n_fail++; $display("FAIL up5_enable got cnt=%0d first=%0d exp=5/0", en_cnt, first_en); end
        n_checks++; if (done_idx !== 5 || done_cnt !== 1 || ab_at_done !== 1'b0) begin
            n_fail++; $display("FAIL up5_done got idx=%0d cnt=%0d ab=%b exp=5/1/0", done_idx, done_cnt, ab_at_done); end
        n_checks++; if (mode_seen !== 2'b00 || bus.load_seen !== 1'b0 || bus.wrap_cnt !== 8'h00) begin
            n_fail++; $display("FAIL up5_status got mode=%b ls=%b wrap=%h exp=00/0/00", mode_seen, bus.load_seen, bus.wrap_cnt); end
    endtask

    task automatic test_load();
        issue(2'b11, 4'hA, 16'd9);
        observe(6);
        n_checks++; if (en_cnt !== 1 || mode_seen !== 2'b11 || d_seen !== 4'hA) begin
            n_fail++; $display("FAIL load_drive got cnt=%0d mode=%b d=%h exp=1/11/a", en_cnt, mode_seen, d_seen); end
        n_checks++; if (done_idx !== 1 || bus.load_seen !== 1'b1) begin
            n_fail++; $display("FAIL load_done got idx=%0d ls=%b exp=1/1", done_idx, bus.load_seen); end
    endtask

    task automatic test_wrap();
        bus.cnt_rco = 1'b1;
        issue(2'b00, 4'h0, 16'd300);
        n_checks++; if (bus.load_seen !== 1'b0 || bus.wrap_cnt !== 8'h00) begin
            n_fail++; $display("FAIL wrap_clr got ls=%b wrap=%h exp=0/00", bus.load_seen, bus.wrap_cnt); end
        observe(305);
        n_checks++; if (en_cnt !== 300 || done_idx !== 300) begin
            n_fail++; $display("FAIL wrap_len got cnt=%0d idx=%0d exp=300/300", en_cnt, done_idx); end
        n_checks++; if (bus.wrap_cnt !== 8'hFF) begin n_fail++; $display("FAIL wrap_sat got=%h exp=ff", bus.wrap_cnt); end
        tick(); tick(); tick();
        n_checks++; if (bus.wrap_cnt !== 8'hFF) begin n_fail++; $display("FAIL wrap_hold got=%h exp=ff", bus.wrap_cnt); end
        issue(2'b10, 4'h3, 16'd3);
        n_checks++; if (bus.wrap_cnt !== 8'h00) begin n_fail++; $display("FAIL wrap_reclr got=%h exp=00", bus.wrap_cnt); end
        observe(6);
        n_checks++; if (bus.wrap_cnt !== 8'h03 || mode_seen !== 2'b10 || d_seen !== 4'h3) begin
            n_fail++; $display("FAIL wrap_three got wrap=%h mode=%b d=%h exp=03/10/3", bus.wrap_cnt, mode_seen, d_seen); end
        bus.cnt_rco = 1'b0;
    endtask

    task automatic test_abort();
        int n_en;
        n_en = 0;
        issue(2'b01, 4'h5, 16'd100);
        for (int j = 0; j < 9; j++) begin
            if (bus.cnt_enable) n_en++;
            tick();
        end
        if (bus.cnt_enable) n_en++;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_checks++; if (n_en !== 10 || bus.cnt_enable !== 1'b0) begin
            n_fail++; $display("FAIL abort_en got cnt=%0d en=%b exp=10/0", n_en, bus.cnt_enable); end
        n_checks++; if (bus.done !== 1'b1 || bus.aborted !== 1'b1 || bus.cnt_mode !== 2'b01) begin
            n_fail++; $display("FAIL abort_done got done=%b ab=%b mode=%b exp=1/1/01", bus.done, bus.aborted, bus.cnt_mode); end
        bus.cmd_op = 2'b00; bus.cmd_data = 4'h1; bus.cmd_len = 16'd2; bus.cmd_valid = 1'b1;
        n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready_done got=%b exp=0", bus.cmd_ready); end
        tick();
        n_checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle got ready=%b busy=%b done=%b exp=1/0/0", bus.cmd_ready, bus.busy, bus.done); end
        tick();
        bus.cmd_valid = 1'b0;
        n_checks++; if (bus.busy !== 1'b1 || bus.cnt_enable !== 1'b1 || bus.aborted !== 1'b0) begin
            n_fail++; $display("FAIL abort_next got busy=%b en=%b ab=%b exp=1/1/0", bus.busy, bus.cnt_enable, bus.aborted); end
        // Abort on the final enabled cycle of this 2-cycle command still reports aborted.
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_checks++; if (bus.done !== 1'b1 || bus.aborted !== 1'b1) begin
            n_fail++; $display("FAIL abort_last got done=%b ab=%b exp=1/1", bus.done, bus.aborted); end
        tick();
        bus.abort = 1'b1;
        tick(); tick();
        bus.abort = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_idle_ign got busy=%b done=%b ready=%b exp=0/0/1", bus.busy, bus.done, bus.cmd_ready); end
    endtask

    task automatic test_zero_len();
        bus.cmd_op = 2'b00; bus.cmd_data = 4'h7; bus.cmd_len = 16'd0; bus.cmd_valid = 1'b1;
        tick();
        n_checks++; if (bus.done !== 1'b1 || bus.cnt_enable !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL zero_done got done=%b en=%b ready=%b busy=%b exp=1/0/0/1", bus.done, bus.cnt_enable, bus.cmd_ready, bus.busy); end
        tick();
        n_checks++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_held got done=%b ready=%b busy=%b exp=0/1/0", bus.done, bus.cmd_ready, bus.busy); end
        tick();
        bus.cmd_valid = 1'b0;
        n_checks++; if (bus.done !== 1'b1 || bus.aborted !== 1'b0) begin
            n_fail++; $display("FAIL zero_reaccept got done=%b ab=%b exp=1/0", bus.done, bus.aborted); end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_data = 4'h0; bus.cmd_len = 16'd0;
        bus.abort = 1'b0; bus.cnt_rco = 1'b0;
        #12;
        test_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        test_reset_mid_run();
        test_mode_up();
        test_load();
        test_wrap();
        test_abort();
        test_zero_len();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
